// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants, state encoding and helpers
//
// Contents:
//   SEG_TABLE         7-bit segment words (a..g in bit6..bit0) for hex digits 0..F
//   STABLE_CYCLES_MIN lower bound of the decoder debounce parameter
//   STABLE_CYCLES_MAX upper bound of the decoder debounce parameter
//   dec_state_t       byte decoder FSM encoding
//   seg7_encode()     nibble -> segment word, used by the segment encoder
package seg7_pkg;

   localparam int unsigned STABLE_CYCLES_MIN = 2;
   localparam int unsigned STABLE_CYCLES_MAX = 255;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47
   };

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_EMIT   = 2'd1,
      ST_HOLD   = 2'd2
   } dec_state_t;

   function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_nibble_decode.sv
// rtl/seg7_nibble_decode.sv - combinational segment word to nibble lookup
//
// Ports:
//   seg    in   7  segment word, bit6..bit0 = a..g, 1 = lit
//   nibble out  4  decoded hex digit (0 when hit is low)
//   hit    out  1  seg matched an entry of SEG_TABLE
module seg7_nibble_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       hit
);

   always_comb begin
      nibble = 4'd0;
      hit    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            nibble = 4'(i);
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_byte_decoder.sv
// rtl/seg7_byte_decoder.sv - debounced two-digit seven-segment to byte decoder
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to accept a pair
// Ports:
//   clkIN     in   1  clock, rising edge
//   rstIN     in   1  synchronous active-high reset
//   segHiIN   in   7  segment word of the high nibble
//   segLoIN   in   7  segment word of the low nibble
//   dataOUT   out  8  decoded byte {hi, lo}
//   validOUT  out  1  dataOUT holds an unconsumed byte
//   readyIN   in   1  consumer takes dataOUT when validOUT && readyIN
//   errOUT    out  1  pulse: stable pair contained an undecodable word
//   ovfOUT    out  1  pulse: decoded byte dropped, output register full
module seg7_byte_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
)(
   input  logic       clkIN,
   input  logic       rstIN,
   input  logic [6:0] segHiIN,
   input  logic [6:0] segLoIN,
   output logic [7:0] dataOUT,
   output logic       validOUT,
   input  logic       readyIN,
   output logic       errOUT,
   output logic       ovfOUT
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   logic [13:0] s0_q, s1_q;
   logic [7:0]  cnt_q, cnt_d;
   dec_state_t  state_q, state_d;

   logic [3:0]  hi_nib, lo_nib;
   logic        hi_hit, lo_hit;
   logic        changed, emit, pair_ok;

   // S1 is the sample the counter has confirmed, so it is the one decoded in
   // EMIT even if S0 has already moved on to a new pair.
   seg7_nibble_decode u_dec_hi (
      .seg    (s1_q[13:7]),
      .nibble (hi_nib),
      .hit    (hi_hit)
   );

   seg7_nibble_decode u_dec_lo (
      .seg    (s1_q[6:0]),
      .nibble (lo_nib),
      .hit    (lo_hit)
   );

   assign changed = (s0_q != s1_q);
   assign emit    = (state_q == ST_EMIT);
   assign pair_ok = hi_hit && lo_hit;

   always_comb begin
      cnt_d = cnt_q;
      if (changed) begin
         cnt_d = 8'd0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         // Looking at the counter's next value lets EMIT start on the same
         // edge the counter saturates, giving STABLE_CYCLES+2 edge latency.
         ST_SETTLE: if (cnt_d == CNT_MAX) state_d = ST_EMIT;
         ST_EMIT:   state_d = ST_HOLD;
         // A change seen during EMIT clears the counter before HOLD can look
         // at S0/S1, so a non-saturated counter also means the pair moved.
         ST_HOLD:   if (changed || (cnt_q != CNT_MAX)) state_d = ST_SETTLE;
         default:   state_d = ST_SETTLE;
      endcase
   end

   always_ff @(posedge clkIN) begin
      if (rstIN) begin
         s0_q     <= 14'd0;
         s1_q     <= 14'd0;
         cnt_q    <= 8'd0;
         state_q  <= ST_SETTLE;
         dataOUT  <= 8'd0;
         validOUT <= 1'b0;
         errOUT   <= 1'b0;
         ovfOUT   <= 1'b0;
      end else begin
         s0_q    <= {segHiIN, segLoIN};
         s1_q    <= s0_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         errOUT  <= emit && !pair_ok;
         ovfOUT  <= 1'b0;
         if (emit && pair_ok) begin
            if (!validOUT || readyIN) begin
               dataOUT  <= {hi_nib, lo_nib};
               validOUT <= 1'b1;
            end else begin
               ovfOUT <= 1'b1;
            end
         end else if (readyIN) begin
            validOUT <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// tb/tb_seg7_byte_decoder.sv - scoreboard testbench for seg7_byte_decoder
module tb_seg7_byte_decoder;

   logic       clkIN = 1'b0;
   logic       rstIN = 1'b1;
   logic [6:0] segHiIN = 7'h00;
   logic [6:0] segLoIN = 7'h00;
   logic       readyIN = 1'b1;
   logic [7:0] dataOUT;
   logic       validOUT;
   logic       errOUT;
   logic       ovfOUT;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         err_seen = 0;
   int         ovf_seen = 0;
   logic [7:0] exp_q [$];

   seg7_byte_decoder #(.STABLE_CYCLES(4)) dut (
      .clkIN    (clkIN),
      .rstIN    (rstIN),
      .segHiIN  (segHiIN),
      .segLoIN  (segLoIN),
      .dataOUT  (dataOUT),
      .validOUT (validOUT),
      .readyIN  (readyIN),
      .errOUT   (errOUT),
      .ovfOUT   (ovfOUT)
   );

   always #5 clkIN = ~clkIN;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clkIN);
      #1;
   endtask

   task automatic pair(input logic [6:0] hi, input logic [6:0] lo);
      segHiIN = hi;
      segLoIN = lo;
   endtask

   // Monitor: every handshake pops the scoreboard; pulses are tallied.
   always @(negedge clkIN) begin
      if (!rstIN) begin
         if (errOUT) err_seen++;
         if (ovfOUT) ovf_seen++;
         if (validOUT && readyIN) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_byte: got %0h expected none", dataOUT);
            end else begin
               check("byte", dataOUT, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      pair(7'h79, 7'h7E);
      edges(2);
      check("rst_data", dataOUT, 8'h00);
      check("rst_valid", validOUT, 0);
      check("rst_err", errOUT, 0);
      check("rst_ovf", ovfOUT, 0);

      // Latency from first post-release edge and single emission while held
      exp_q.push_back(8'h30);
      rstIN = 1'b0;
      edges(5);
      check("lat_early", validOUT, 0);
      edges(1);
      check("lat_valid", validOUT, 1);
      check("lat_data", dataOUT, 8'h30);
      edges(1);
      check("lat_consumed", validOUT, 0);
      edges(20);
      check("held_once", validOUT, 0);

      // Unstable pair is ignored, following stable pair decodes
      pair(7'h77, 7'h1F);
      edges(2);
      pair(7'h47, 7'h0D);
      exp_q.push_back(8'hFC);
      edges(12);
      check("glitch_data", dataOUT, 8'hFC);
      check("glitch_err", err_seen, 0);

      // Blank word is an error, no byte
      pair(7'h00, 7'h30);
      edges(12);
      check("err_count", err_seen, 1);
      check("err_valid", validOUT, 0);
      check("err_data", dataOUT, 8'hFC);

      // Overflow while consumer stalls
      readyIN = 1'b0;
      pair(7'h30, 7'h30);
      exp_q.push_back(8'h11);
      edges(10);
      check("stall_valid", validOUT, 1);
      check("stall_data", dataOUT, 8'h11);
      pair(7'h6D, 7'h6D);
      edges(10);
      check("ovf_count", ovf_seen, 1);
      check("ovf_data", dataOUT, 8'h11);
      check("ovf_valid", validOUT, 1);
      readyIN = 1'b1;
      edges(1);
      check("drain_valid", validOUT, 0);

      // Reset mid-settle with a pending byte
      readyIN = 1'b0;
      pair(7'h30, 7'h30);
      edges(10);
      check("pre_rst_valid", validOUT, 1);
      check("pre_rst_data", dataOUT, 8'h11);
      pair(7'h7B, 7'h5B);
      edges(4);
      rstIN = 1'b1;
      edges(1);
      check("mid_rst_data", dataOUT, 8'h00);
      check("mid_rst_valid", validOUT, 0);
      check("mid_rst_err", errOUT, 0);
      check("mid_rst_ovf", ovfOUT, 0);
      rstIN = 1'b0;
      readyIN = 1'b1;
      exp_q.push_back(8'h95);
      edges(5);
      check("post_rst_early", validOUT, 0);
      edges(1);
      check("post_rst_valid", validOUT, 1);
      check("post_rst_data", dataOUT, 8'h95);
      edges(8);

      // Same pair decoded again after an intervening pair
      pair(7'h79, 7'h7E);
      exp_q.push_back(8'h30);
      edges(10);
      pair(7'h33, 7'h33);
      exp_q.push_back(8'h44);
      edges(10);
      pair(7'h79, 7'h7E);
      exp_q.push_back(8'h30);
      edges(10);

      check("queue_empty", exp_q.size(), 0);
      check("final_err", err_seen, 1);
      check("final_ovf", ovf_seen, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
